// File: rtl/motor_drive_sequencer_if.sv
// Command, speed-feedback and status bundle between the drive sequencer and its user.
// The user side (testbench or supervisor) takes master, the sequencer takes slave.
interface motor_drive_sequencer_if #(
    parameter int K_PWMRES   = 10,
    parameter int K_SPDWIDTH = 15
);
    logic                  i_enable;
    logic [K_PWMRES-1:0]   i_target_duty;
    logic                  i_target_reverse;
    logic [K_PWMRES-1:0]   i_ramp_step;
    logic [K_SPDWIDTH-1:0] i_speed;
    logic                  i_speed_valid;
    logic [K_SPDWIDTH-1:0] i_stop_thr;
    logic [3:0]            i_stall_windows;
    logic                  i_fault_clear;
    logic [K_PWMRES-1:0]   o_pwm_command;
    logic                  o_reverse;
    logic                  o_brake;
    logic [2:0]            o_state;
    logic                  o_fault;

    modport master (
        output i_enable, i_target_duty, i_target_reverse, i_ramp_step,
               i_speed, i_speed_valid, i_stop_thr, i_stall_windows, i_fault_clear,
        input  o_pwm_command, o_reverse, o_brake, o_state, o_fault
    );

    modport slave (
        input  i_enable, i_target_duty, i_target_reverse, i_ramp_step,
               i_speed, i_speed_valid, i_stop_thr, i_stall_windows, i_fault_clear,
        output o_pwm_command, o_reverse, o_brake, o_state, o_fault
    );
endinterface

// File: rtl/motor_drive_sequencer.sv
// Supervisory duty-ramp / reversal / stall-fault sequencer feeding the motor control top.
// Reversals always pass through decelerate and brake-until-stopped before re-accelerating.
module motor_drive_sequencer #(
    parameter int K_PWMRES   = 10,
    parameter int K_SPDWIDTH = 15,
    parameter int K_RAMP_DIV = 16
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    motor_drive_sequencer_if.slave  bus
);
    localparam int PW = $clog2(K_RAMP_DIV);
    localparam logic [PW-1:0]       PRESC_LAST = PW'(K_RAMP_DIV - 1);
    localparam logic [PW-1:0]       PRESC_ONE  = PW'(1);
    localparam logic [K_PWMRES-1:0] CMD_ONE    = K_PWMRES'(1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RAMP  = 3'd1,
        ST_RUN   = 3'd2,
        ST_DECEL = 3'd3,
        ST_BRAKE = 3'd4,
        ST_FAULT = 3'd5
    } state_t;

    state_t              state_q, state_d;
    logic [K_PWMRES-1:0] cmd_q, cmd_d;
    logic                rev_q, rev_d;
    logic                brake_q, brake_d;
    logic                fault_q, fault_d;
    logic [PW-1:0]       presc_q, presc_d;
    logic [3:0]          stall_q, stall_d;

    logic                tick;
    logic [K_PWMRES-1:0] step_eff;
    logic [K_PWMRES-1:0] next_ramp;
    logic [K_PWMRES-1:0] next_decel;
    logic                want_drive;
    logic                leave_drive;
    logic                stall_active;
    logic                zero_sample;
    logic [3:0]          stall_inc;
    logic                stall_hit;

    // One step toward the target; the extra bit keeps sums from wrapping.
    function automatic logic [K_PWMRES-1:0] ramp_toward(
        input logic [K_PWMRES-1:0] cur,
        input logic [K_PWMRES-1:0] tgt,
        input logic [K_PWMRES-1:0] stp
    );
        logic [K_PWMRES:0] up_sum;
        logic [K_PWMRES:0] dn_lim;
        up_sum = {1'b0, cur} + {1'b0, stp};
        dn_lim = {1'b0, tgt} + {1'b0, stp};
        if (cur <= tgt)
            ramp_toward = (up_sum > {1'b0, tgt}) ? tgt : up_sum[K_PWMRES-1:0];
        else
            ramp_toward = ({1'b0, cur} < dn_lim) ? tgt : cur - stp;
    endfunction

    function automatic logic [K_PWMRES-1:0] decel_toward_zero(
        input logic [K_PWMRES-1:0] cur,
        input logic [K_PWMRES-1:0] stp
    );
        decel_toward_zero = (cur <= stp) ? '0 : cur - stp;
    endfunction

    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        rev_d   = rev_q;
        presc_d = '0;
        stall_d = stall_q;

        tick         = (presc_q == PRESC_LAST);
        step_eff     = (bus.i_ramp_step == '0) ? CMD_ONE : bus.i_ramp_step;
        next_ramp    = ramp_toward(cmd_q, bus.i_target_duty, step_eff);
        next_decel   = decel_toward_zero(cmd_q, step_eff);
        want_drive   = bus.i_enable && (bus.i_target_duty != '0);
        leave_drive  = !bus.i_enable || (bus.i_target_reverse != rev_q);
        stall_active = ((state_q == ST_RAMP) || (state_q == ST_RUN)) && (cmd_q != '0);
        zero_sample  = bus.i_speed_valid && (bus.i_speed == '0);
        stall_inc    = (stall_q == 4'hF) ? stall_q : stall_q + 4'd1;
        stall_hit    = stall_active && zero_sample && (bus.i_stall_windows != 4'd0) &&
                       (stall_inc == bus.i_stall_windows);

        if (!stall_active)
            stall_d = '0;
        else if (bus.i_speed_valid)
            stall_d = zero_sample ? stall_inc : 4'd0;

        unique case (state_q)
            ST_IDLE: begin
                cmd_d = '0;
                if (want_drive) begin
                    state_d = ST_RAMP;
                    rev_d   = bus.i_target_reverse;
                end
            end
            ST_RAMP: begin
                if (stall_hit) begin
                    state_d = ST_FAULT;
                end else if (leave_drive) begin
                    state_d = ST_DECEL;
                end else begin
                    presc_d = tick ? '0 : presc_q + PRESC_ONE;
                    if (tick) begin
                        cmd_d = next_ramp;
                        if (next_ramp == bus.i_target_duty)
                            state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (stall_hit)
                    state_d = ST_FAULT;
                else if (leave_drive)
                    state_d = ST_DECEL;
                else if (bus.i_target_duty != cmd_q)
                    state_d = ST_RAMP;
            end
            ST_DECEL: begin
                presc_d = tick ? '0 : presc_q + PRESC_ONE;
                if (tick) begin
                    cmd_d = next_decel;
                    if (next_decel == '0)
                        state_d = ST_BRAKE;
                end
            end
            ST_BRAKE: begin
                cmd_d = '0;
                if (bus.i_speed_valid && (bus.i_speed < bus.i_stop_thr)) begin
                    if (want_drive) begin
                        state_d = ST_RAMP;
                        rev_d   = bus.i_target_reverse;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_FAULT: begin
                cmd_d = '0;
                if (bus.i_fault_clear && !bus.i_enable)
                    state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cmd_d   = '0;
            end
        endcase

        // Counter only lives while the drive is actually pushing torque.
        if ((state_d != ST_RAMP) && (state_d != ST_RUN))
            stall_d = '0;
        if (state_d == ST_FAULT)
            cmd_d = '0;
        brake_d = (state_d == ST_BRAKE) || (state_d == ST_FAULT);
        fault_d = (state_d == ST_FAULT);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            cmd_q   <= '0;
            rev_q   <= 1'b0;
            brake_q <= 1'b0;
            fault_q <= 1'b0;
            presc_q <= '0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            rev_q   <= rev_d;
            brake_q <= brake_d;
            fault_q <= fault_d;
            presc_q <= presc_d;
            stall_q <= stall_d;
        end
    end

    assign bus.o_pwm_command = cmd_q;
    assign bus.o_reverse     = rev_q;
    assign bus.o_brake       = brake_q;
    assign bus.o_state       = state_q;
    assign bus.o_fault       = fault_q;
endmodule

// File: tb/tb_motor_drive_sequencer.sv
// Scoreboard bench for motor_drive_sequencer: directed scenarios plus randomized traffic,
// expected outputs come from a cycle-level behavioural model of the sequencing rules.
module tb_motor_drive_sequencer;
    localparam int PWMRES = 10;
    localparam int SPDW   = 15;
    localparam int DIV    = 4;
    localparam int S_IDLE = 0, S_RAMP = 1, S_RUN = 2, S_DECEL = 3, S_BRAKE = 4, S_FAULT = 5;

    logic clk = 1'b0;
    logic rst;

    motor_drive_sequencer_if #(.K_PWMRES(PWMRES), .K_SPDWIDTH(SPDW)) bus();

    motor_drive_sequencer #(
        .K_PWMRES(PWMRES), .K_SPDWIDTH(SPDW), .K_RAMP_DIV(DIV)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cmd;
        int rev;
        int brake;
        int state;
        int fault;
    } exp_t;

    exp_t sb[$];
    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state; cycles_left counts edges until the next ramp step.
    int m_state, m_cmd, m_rev, m_brake, m_fault, m_cycles_left, m_zero_run;

    task automatic check(input string name, input int act, input int want);
        n_cmp++;
        if (act != want) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, want);
        end
    endtask

    task automatic model_reset();
        m_state = S_IDLE; m_cmd = 0; m_rev = 0; m_brake = 0; m_fault = 0;
        m_cycles_left = DIV; m_zero_run = 0;
    endtask

    task automatic model_step();
        int  tgt, stp, win, nstate, ncmd, nrev;
        bit  drive, leave, tick, torque, fault_now, stopped;
        tgt     = int'(bus.i_target_duty);
        stp     = (bus.i_ramp_step == 0) ? 1 : int'(bus.i_ramp_step);
        win     = int'(bus.i_stall_windows);
        drive   = bus.i_enable && tgt != 0;
        leave   = !bus.i_enable || (int'(bus.i_target_reverse) != m_rev);
        torque  = (m_state == S_RAMP || m_state == S_RUN) && m_cmd != 0;
        stopped = bus.i_speed_valid && (bus.i_speed < bus.i_stop_thr);
        nstate  = m_state; ncmd = m_cmd; nrev = m_rev;
        fault_now = 0;
        tick      = 0;

        if (!torque) m_zero_run = 0;
        else if (bus.i_speed_valid) begin
            if (bus.i_speed == 0) begin
                m_zero_run++;
                if (win != 0 && m_zero_run == win) fault_now = 1;
            end else m_zero_run = 0;
        end

        if (m_state == S_RAMP || m_state == S_DECEL) begin
            m_cycles_left--;
            if (m_cycles_left == 0) begin
                tick = 1;
                m_cycles_left = DIV;
            end
        end

        case (m_state)
            S_IDLE: if (drive) begin nstate = S_RAMP; nrev = bus.i_target_reverse; m_cycles_left = DIV; end
            S_RAMP: begin
                if (fault_now) nstate = S_FAULT;
                else if (leave) begin nstate = S_DECEL; m_cycles_left = DIV; end
                else if (tick) begin
                    if (m_cmd < tgt) ncmd = (m_cmd + stp > tgt) ? tgt : m_cmd + stp;
                    else             ncmd = (m_cmd - stp < tgt) ? tgt : m_cmd - stp;
                    if (ncmd == tgt) nstate = S_RUN;
                end
            end
            S_RUN: begin
                if (fault_now) nstate = S_FAULT;
                else if (leave) begin nstate = S_DECEL; m_cycles_left = DIV; end
                else if (tgt != m_cmd) begin nstate = S_RAMP; m_cycles_left = DIV; end
            end
            S_DECEL: if (tick) begin
                ncmd = (m_cmd - stp < 0) ? 0 : m_cmd - stp;
                if (ncmd == 0) nstate = S_BRAKE;
            end
            S_BRAKE: if (stopped) begin
                if (drive) begin nstate = S_RAMP; nrev = bus.i_target_reverse; m_cycles_left = DIV; end
                else nstate = S_IDLE;
            end
            S_FAULT: if (bus.i_fault_clear && !bus.i_enable) nstate = S_IDLE;
            default: nstate = S_IDLE;
        endcase

        if (nstate == S_IDLE || nstate == S_BRAKE || nstate == S_FAULT) ncmd = 0;
        if (nstate != S_RAMP && nstate != S_RUN) m_zero_run = 0;
        m_state = nstate; m_cmd = ncmd; m_rev = nrev;
        m_brake = (nstate == S_BRAKE || nstate == S_FAULT);
        m_fault = (nstate == S_FAULT);
    endtask

    // Called just after a falling edge with inputs settled; ends at the next falling edge.
    task automatic step_cycle();
        exp_t e;
        if (rst) model_reset();
        else model_step();
        e.cmd = m_cmd; e.rev = m_rev; e.brake = m_brake; e.state = m_state; e.fault = m_fault;
        sb.push_back(e);
        @(negedge clk);
    endtask

    task automatic run(input int n);
        repeat (n) step_cycle();
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_cmd"},   int'(bus.o_pwm_command), 0);
        check({tag, "_rev"},   int'(bus.o_reverse),     0);
        check({tag, "_brake"}, int'(bus.o_brake),       0);
        check({tag, "_state"}, int'(bus.o_state),       S_IDLE);
        check({tag, "_fault"}, int'(bus.o_fault),       0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                n_cmp++;
                if (int'(bus.o_pwm_command) != e.cmd || int'(bus.o_reverse) != e.rev ||
                    int'(bus.o_brake) != e.brake || int'(bus.o_state) != e.state ||
                    int'(bus.o_fault) != e.fault) begin
                    n_bad++;
                    $display("FAIL scoreboard t=%0t: got cmd=%0d rev=%0d brake=%0d state=%0d fault=%0d, expected cmd=%0d rev=%0d brake=%0d state=%0d fault=%0d",
                             $time, bus.o_pwm_command, bus.o_reverse, bus.o_brake, bus.o_state, bus.o_fault,
                             e.cmd, e.rev, e.brake, e.state, e.fault);
                end
            end
        end
    end

    initial begin : stimulus
        bus.i_enable = 1'b0; bus.i_target_duty = '0; bus.i_target_reverse = 1'b0;
        bus.i_ramp_step = 10'd100; bus.i_speed = '0; bus.i_speed_valid = 1'b0;
        bus.i_stop_thr = 15'd20; bus.i_stall_windows = 4'd3; bus.i_fault_clear = 1'b0;
        rst = 1'b0;
        #1 rst = 1'b1;
        #1 check_reset_values("reset");
        @(negedge clk);
        step_cycle();
        rst = 1'b0;

        // Basic ramp: 0 -> 350 in steps of 100, one step per 4 cycles.
        bus.i_enable = 1'b1; bus.i_target_duty = 10'd350;
        run(1);
        check("ramp_entry_state", int'(bus.o_state), S_RAMP);
        run(4);
        check("ramp_first_step", int'(bus.o_pwm_command), 100);
        run(12);
        check("ramp_done_cmd", int'(bus.o_pwm_command), 350);
        check("ramp_done_state", int'(bus.o_state), S_RUN);

        // Reversal: decelerate, brake, then re-accelerate in the other direction.
        bus.i_target_reverse = 1'b1;
        run(1);
        check("rev_decel_state", int'(bus.o_state), S_DECEL);
        check("rev_held_during_decel", int'(bus.o_reverse), 0);
        run(16);
        check("rev_brake_state", int'(bus.o_state), S_BRAKE);
        check("rev_brake_on", int'(bus.o_brake), 1);
        bus.i_speed = 15'd10; bus.i_speed_valid = 1'b1;
        run(1);
        bus.i_speed_valid = 1'b0;
        check("rev_reramp_state", int'(bus.o_state), S_RAMP);
        check("rev_flipped", int'(bus.o_reverse), 1);
        check("rev_brake_off", int'(bus.o_brake), 0);

        // Stall: three zero-speed samples in RUN at 200.
        bus.i_target_duty = 10'd200;
        run(8);
        check("stall_run_cmd", int'(bus.o_pwm_command), 200);
        bus.i_speed = '0; bus.i_speed_valid = 1'b1;
        run(2);
        check("stall_not_yet", int'(bus.o_state), S_RUN);
        run(1);
        bus.i_speed_valid = 1'b0;
        check("stall_fault_state", int'(bus.o_state), S_FAULT);
        check("stall_fault_flag", int'(bus.o_fault), 1);
        check("stall_fault_cmd", int'(bus.o_pwm_command), 0);
        bus.i_fault_clear = 1'b1;
        run(1);
        check("fault_clear_enabled", int'(bus.o_state), S_FAULT);
        bus.i_enable = 1'b0;
        run(1);
        bus.i_fault_clear = 1'b0;
        check("fault_clear_idle", int'(bus.o_state), S_IDLE);

        // Saturation at full scale and on the way down.
        bus.i_target_reverse = 1'b0;
        bus.i_enable = 1'b1; bus.i_target_duty = 10'd900; bus.i_ramp_step = 10'd1023;
        run(5);
        check("sat_900", int'(bus.o_pwm_command), 900);
        bus.i_target_duty = 10'd1023;
        run(5);
        check("sat_1023", int'(bus.o_pwm_command), 1023);
        bus.i_target_duty = 10'd5;
        run(5);
        check("sat_down_5", int'(bus.o_pwm_command), 5);
        bus.i_enable = 1'b0;
        run(5);
        check("sat_decel_brake", int'(bus.o_state), S_BRAKE);
        bus.i_speed = 15'd3; bus.i_speed_valid = 1'b1;
        run(1);
        bus.i_speed_valid = 1'b0;
        check("brake_to_idle", int'(bus.o_state), S_IDLE);

        // Asynchronous reset in the middle of a ramp.
        bus.i_ramp_step = 10'd100; bus.i_target_duty = 10'd350;
        bus.i_target_reverse = 1'b1; bus.i_enable = 1'b1;
        run(9);
        check("midramp_cmd", int'(bus.o_pwm_command), 200);
        rst = 1'b1;
        #1 check_reset_values("async_reset");
        step_cycle();
        rst = 1'b0;
        run(5);
        check("restart_cmd", int'(bus.o_pwm_command), 100);

        // Stall and disable arriving together: fault wins.
        run(12);
        check("simul_run", int'(bus.o_state), S_RUN);
        bus.i_speed = '0; bus.i_speed_valid = 1'b1;
        run(2);
        bus.i_enable = 1'b0;
        run(1);
        bus.i_speed_valid = 1'b0;
        check("simul_fault", int'(bus.o_state), S_FAULT);
        bus.i_fault_clear = 1'b1;
        run(1);
        bus.i_fault_clear = 1'b0;
        check("simul_clear", int'(bus.o_state), S_IDLE);

        // Randomized traffic in segments, each with its own stall window.
        for (int seg = 0; seg < 4; seg++) begin
            rst = 1'b1;
            bus.i_stall_windows = 4'($urandom_range(4));
            step_cycle();
            rst = 1'b0;
            for (int c = 0; c < 1500; c++) begin
                if ($urandom_range(99) < 5)
                    bus.i_target_duty = ($urandom_range(9) == 0) ? 10'd0 : 10'($urandom_range(1023));
                if ($urandom_range(99) < 2) bus.i_target_reverse = ~bus.i_target_reverse;
                if (bus.i_enable) begin
                    if ($urandom_range(99) < 2) bus.i_enable = 1'b0;
                end else if ($urandom_range(99) < 8) bus.i_enable = 1'b1;
                if ($urandom_range(99) < 4) begin
                    case ($urandom_range(9))
                        0:       bus.i_ramp_step = 10'd0;
                        1:       bus.i_ramp_step = 10'd1023;
                        default: bus.i_ramp_step = 10'($urandom_range(300, 1));
                    endcase
                end
                bus.i_speed_valid = ($urandom_range(3) == 0);
                bus.i_speed       = $urandom_range(1) ? 15'd0 : 15'($urandom_range(100, 1));
                bus.i_stop_thr    = 15'($urandom_range(60));
                bus.i_fault_clear = ($urandom_range(19) == 0);
                step_cycle();
            end
        end

        bus.i_speed_valid = 1'b0;
        bus.i_fault_clear = 1'b0;
        run(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
